// File: rtl/flp_burst_scheduler_if.sv
// flp_burst_scheduler_if: control inputs and pulse/status outputs of the FLP burst scheduler
interface flp_burst_scheduler_if;
  logic        en;
  logic [15:0] lcw;
  logic        ack;
  logic        tx_pulse;
  logic        burst_active;
  logic [5:0]  slot;
  logic [7:0]  burst_cnt;
  logic        ack_done;
  modport master (output en, lcw, ack, input tx_pulse, burst_active, slot, burst_cnt, ack_done);
  modport slave (input en, lcw, ack, output tx_pulse, burst_active, slot, burst_cnt, ack_done);
endinterface

// File: rtl/flp_burst_scheduler.sv
// flp_burst_scheduler: sequences 100BASE-T FLP bursts (17 clock + 16 data pulses) on CLK16
module flp_burst_scheduler #(
  parameter int PULSE_W    = 2,
  parameter int SLOT_CYC   = 1000,
  parameter int BURST_GAP  = 256000,
  parameter int ACK_BURSTS = 6
) (
  input logic CLK16,
  input logic RSTn,
  flp_burst_scheduler_if.slave bus
);
  localparam int TW = $clog2(SLOT_CYC);
  localparam int GW = $clog2(BURST_GAP);
  localparam int AW = $clog2(ACK_BURSTS + 1);
  typedef enum logic [1:0] {IDLE, BURST, GAP} state_t;
  state_t state, state_nx;
  logic [TW-1:0] tmr;
  logic [5:0]    slot_idx;
  logic [GW-1:0] gap;
  logic [15:0]   word;
  logic          ack_flag;
  logic [AW-1:0] ack_cnt;
  logic          slot_end, burst_end, gap_end, start, pulse;
  // next state plus the slot/burst/gap boundary decodes and the unregistered pulse level
  always_comb begin
    slot_end  = tmr == TW'(SLOT_CYC - 1);
    burst_end = state == BURST && slot_idx == 6'd32 && tmr == TW'(PULSE_W - 1);
    gap_end   = state == GAP && gap == GW'(BURST_GAP - 1);
    start     = bus.en && (state == IDLE || gap_end);
    pulse     = state == BURST && tmr < TW'(PULSE_W) && (slot_idx[0] ? word[slot_idx[4:1]] : 1'b1);
    state_nx  = !bus.en ? IDLE : state == IDLE ? BURST : burst_end ? GAP : gap_end ? BURST : state;
  end
  // state register
  always_ff @(posedge CLK16 or negedge RSTn)
    if (!RSTn) state <= IDLE;
    else state <= state_nx;
  // timers, latched word, completion counters and the output register stage
  always_ff @(posedge CLK16 or negedge RSTn)
    if (!RSTn || !bus.en) begin
      tmr              <= '0;
      slot_idx         <= '0;
      gap              <= '0;
      word             <= '0;
      ack_flag         <= 1'b0;
      ack_cnt          <= '0;
      bus.tx_pulse     <= 1'b0;
      bus.burst_active <= 1'b0;
      bus.slot         <= '0;
      bus.burst_cnt    <= '0;
      bus.ack_done     <= 1'b0;
    end else begin
      tmr      <= (state_nx != BURST || start || slot_end) ? '0 : tmr + TW'(1);
      slot_idx <= (state_nx != BURST || start) ? '0 : slot_idx + 6'(slot_end);
      gap      <= start ? '0 : gap + GW'(1);
      if (start) begin
        word     <= bus.ack ? (bus.lcw | 16'h4000) : bus.lcw;
        ack_flag <= bus.ack;
      end
      if (burst_end) begin
        bus.burst_cnt <= bus.burst_cnt + 8'(bus.burst_cnt != 8'hFF);
        ack_cnt       <= ack_cnt + AW'(ack_flag && ack_cnt != AW'(ACK_BURSTS));
        bus.ack_done  <= bus.ack_done | (ack_flag && ack_cnt == AW'(ACK_BURSTS - 1));
      end
      bus.tx_pulse     <= pulse;
      bus.burst_active <= state == BURST;
      bus.slot         <= slot_idx;
    end
endmodule

// File: tb/tb_flp_burst_scheduler.sv
// tb_flp_burst_scheduler: directed self-checking bench for flp_burst_scheduler
module tb_flp_burst_scheduler;
  logic CLK16 = 1'b0;
  logic RSTn  = 1'b1;
  int n_cmp = 0;
  int n_err = 0;
  flp_burst_scheduler_if bus ();
  flp_burst_scheduler #(.PULSE_W(2), .SLOT_CYC(8), .BURST_GAP(300), .ACK_BURSTS(2)) dut (
    .CLK16(CLK16),
    .RSTn (RSTn),
    .bus  (bus)
  );
  always #5 CLK16 = ~CLK16;
  task automatic tick();
    @(posedge CLK16);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask
  // called at the first sample with burst_active high; returns at the sample right after the burst
  task automatic burst_check(input string tag, input logic [15:0] w, input logic [7:0] cnt0,
                             input logic ad0, input logic ad1, input int chg_k, input logic [15:0] chg);
    logic e;
    int s, t;
    chk({tag, "_cnt_start"}, bus.burst_cnt, cnt0);
    chk({tag, "_ackdone_start"}, bus.ack_done, ad0);
    for (int k = 0; k < 258; k++) begin
      if (k == chg_k) bus.lcw = chg;
      s = k / 8;
      t = k % 8;
      e = (t < 2) && ((s % 2 == 0) || w[s/2]);
      chk($sformatf("%s_tx_k%0d", tag, k), bus.tx_pulse, e);
      chk($sformatf("%s_slot_k%0d", tag, k), bus.slot, s);
      chk($sformatf("%s_active_k%0d", tag, k), bus.burst_active, 1);
      tick();
    end
    chk({tag, "_active_end"}, bus.burst_active, 0);
    chk({tag, "_tx_end"}, bus.tx_pulse, 0);
    chk({tag, "_slot_end"}, bus.slot, 0);
    chk({tag, "_cnt_end"}, bus.burst_cnt, cnt0 + 8'd1);
    chk({tag, "_ackdone_end"}, bus.ack_done, ad1);
  endtask
  // from the post-burst sample, wait for the next burst; 42 cycles completes the 300-cycle period
  task automatic gap_check(input string tag);
    int n = 0;
    int hi = 0;
    while (!bus.burst_active && n < 400) begin
      if (bus.tx_pulse) hi++;
      tick();
      n++;
    end
    chk({tag, "_gap_len"}, n, 42);
    chk({tag, "_gap_quiet"}, hi, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    bus.en  = 1'b1;
    bus.lcw = 16'h01E1;
    bus.ack = 1'b0;
    #2 RSTn = 1'b0;
    tick();
    tick();
    tick();
    chk("rst_tx", bus.tx_pulse, 0);
    chk("rst_active", bus.burst_active, 0);
    chk("rst_slot", bus.slot, 0);
    chk("rst_cnt", bus.burst_cnt, 0);
    chk("rst_ackdone", bus.ack_done, 0);
    RSTn = 1'b1;
    tick();
    chk("lat_tx", bus.tx_pulse, 0);
    chk("lat_active", bus.burst_active, 0);
    tick();
    chk("first_pulse", bus.tx_pulse, 1);
    burst_check("b1", 16'h01E1, 8'd0, 1'b0, 1'b0, 100, 16'hFFFF);
    gap_check("g1");
    burst_check("b2", 16'hFFFF, 8'd1, 1'b0, 1'b0, -1, 16'h0000);
    bus.lcw = 16'h01E1;
    bus.ack = 1'b1;
    gap_check("g2");
    burst_check("b3", 16'h41E1, 8'd2, 1'b0, 1'b0, -1, 16'h0000);
    gap_check("g3");
    burst_check("b4", 16'h41E1, 8'd3, 1'b0, 1'b1, -1, 16'h0000);
    bus.ack = 1'b0;
    gap_check("g4");
    burst_check("b5", 16'h01E1, 8'd4, 1'b1, 1'b1, -1, 16'h0000);
    gap_check("g5");
    for (int i = 0; i < 88; i++) tick();
    chk("abort_slot", bus.slot, 11);
    chk("abort_tx_before", bus.tx_pulse, 1);
    bus.en = 1'b0;
    tick();
    chk("abort_tx", bus.tx_pulse, 0);
    chk("abort_active", bus.burst_active, 0);
    chk("abort_slot0", bus.slot, 0);
    chk("abort_cnt", bus.burst_cnt, 0);
    chk("abort_ackdone", bus.ack_done, 0);
    tick();
    tick();
    chk("idle_tx", bus.tx_pulse, 0);
    bus.en = 1'b1;
    tick();
    chk("reen_lat_active", bus.burst_active, 0);
    chk("reen_lat_tx", bus.tx_pulse, 0);
    tick();
    chk("reen_active", bus.burst_active, 1);
    chk("reen_tx", bus.tx_pulse, 1);
    burst_check("b7", 16'h01E1, 8'd0, 1'b0, 1'b0, -1, 16'h0000);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/flp_burst_scheduler.md
Name: flp_burst_scheduler

Overview:
Sequences 100BASE-T auto-negotiation Fast Link Pulse (FLP) bursts on the CLK16 (16 MHz) domain and drives the unipolar pulse line that feeds the TXp output stage. Each burst contains 17 clock pulses interleaved with 16 data-pulse slots carrying a 16-bit Link Code Word (LCW), sent LSB first. Bursts repeat at a fixed interval. The block applies the Acknowledge bit and signals completion after a configured number of acknowledged bursts.

Parameters:
PULSE_W, 2, pulse high time in CLK16 cycles (125 ns)
SLOT_CYC, 1000, slot length in cycles; clock-to-data pulse spacing (62.5 us)
BURST_GAP, 256000, burst-start to burst-start period in cycles (16 ms); must exceed 32*SLOT_CYC+PULSE_W
ACK_BURSTS, 6, number of bursts with Ack=1 required before ack_done asserts

Ports:
CLK16  input  1  system clock, 16 MHz
RSTn  input  1  asynchronous active-low reset
en  input  1  enable burst generation; low aborts and clears
lcw  input  16  Link Code Word; bit 0 is transmitted first
ack  input  1  request Ack: forces lcw bit 14 to 1 in bursts started while high
tx_pulse  output  1  registered pulse line to the TX driver
burst_active  output  1  high for the duration of a burst
slot  output  6  current slot index 0..32 (0 outside a burst)
burst_cnt  output  8  completed bursts since en rose; saturates at 255
ack_done  output  1  sticky; ACK_BURSTS acknowledged bursts have completed

Behaviour:
- Reset (RSTn=0, asynchronous): state=IDLE. All outputs are 0. All counters and the latched word are 0.
- States: IDLE, BURST, GAP. All outputs are registered.
- IDLE: when en is sampled high, enter BURST on the next edge with slot=0, slot timer=0, and gap timer=0.
- Burst start (every entry to BURST):
  - latch word = lcw, with bit 14 forced to 1 if ack=1 at that edge;
  - latch ack_flag = ack.
  - Changes to lcw or ack during the burst are ignored.
- BURST:
  - The slot timer counts 0..SLOT_CYC-1, then wraps and increments slot.
  - Even slot 2j is a clock pulse. tx_pulse=1 for timer 0..PULSE_W-1.
  - Odd slot 2j+1 carries data bit j. tx_pulse=word[j] for timer 0..PULSE_W-1. tx_pulse=0 otherwise.
  - burst_active=1 throughout BURST.
  - Exit to GAP at the edge after timer=PULSE_W-1 in slot 32. Slot 32 is truncated; no idle tail.
- Burst end (the BURST->GAP edge):
  - burst_cnt increments, saturating at 255.
  - If ack_flag=1, the internal ack counter increments (saturating).
  - ack_done sets when the ack counter reaches ACK_BURSTS.
- GAP:
  - tx_pulse=0, burst_active=0, slot=0.
  - The gap timer runs continuously from the burst start.
  - When it reaches BURST_GAP-1, the next edge re-enters BURST with the gap timer at 0.
  - Burst period is exactly BURST_GAP cycles.
- en low in any state: next edge goes to IDLE. tx_pulse=0, burst_active=0, slot=0, burst_cnt=0, ack counter=0, ack_done=0.
  - A burst in progress is aborted mid-pulse; no partial completion is counted.
- en high again: first tx_pulse rises 2 cycles after the en-rise edge (1 cycle IDLE->BURST, 1 cycle output register).
- ack deasserted after ack_done: ack_done stays set. Subsequent bursts carry bit 14=0 unless ack is high.
- ack_done and burst_cnt change only on a burst-end edge or on clear.
- Glitch-free: tx_pulse never toggles except at PULSE_W boundaries.

Test Plan:
Bench parameters: PULSE_W=2, SLOT_CYC=8, BURST_GAP=300, ACK_BURSTS=2.
1. Reset held with en=1, then release -> all outputs 0 during reset. First tx_pulse high 2 cycles after the first en-sampled edge.
2. lcw=16'h01E1, ack=0, one burst -> 33 slots at 8-cycle spacing. Clock slots always 2 cycles high. Data slots j=0,5,6,7,8 high, all others 0. Bit 14 is 0. burst_active high for 258 cycles. burst_cnt=1 after the burst.
3. Continuous run -> burst starts exactly 300 cycles apart. burst_cnt reaches 5 after 5 bursts.
4. Change lcw to 16'hFFFF mid-burst -> the current burst keeps the old pattern. The next burst has all 16 data pulses.
5. Raise ack before burst 3 with lcw=16'h01E1 -> bursts 3 and 4 carry data slot 29 (bit 14) high. ack_done=1 at the end of burst 4. It stays 1 after ack drops.
6. Drop en in slot 11 mid-pulse -> tx_pulse=0 on the next edge. burst_cnt=0, ack_done=0. Re-enable -> a fresh burst starts from slot 0.
